// File: rtl/acq_scheduler.sv
// Code-phase acquisition sweep scheduler.
// Sweeps C/A offsets, tracks the best correlation metric.
module acq_scheduler #(
  parameter int PHASE_COUNT = 1023,
  parameter int HALF        = 5000,
  parameter int TIMEOUT     = 16383
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] sum,
  input  logic        sum_ready,
  input  logic [13:0] threshold,
  output logic        gen_sync,
  output logic        cnt_rst,
  output logic [9:0]  code_phase,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [9:0]  best_phase,
  output logic [13:0] best_metric,
  output logic        timeout_err
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [13:0]    HALF_V = 14'(HALF);
  localparam logic [9:0]     LAST   = 10'(PHASE_COUNT - 1);
  localparam logic [WDW-1:0] WD_END = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SYNC, WAIT, EVAL, NEXT, DONE
  } state_t;

  state_t         state, state_n;
  logic [WDW-1:0] wd;
  logic [13:0]    metric, metric_n;
  logic           found_q, found_now;
  logic           wd_end;

  assign wd_end   = (wd == WD_END);
  assign metric_n = (sum >= HALF_V) ? sum - HALF_V
                                    : HALF_V - sum;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = SYNC;
      SYNC: state_n = WAIT;
      WAIT: begin
        if (sum_ready)   state_n = EVAL;
        else if (wd_end) state_n = DONE;
      end
      EVAL: state_n = NEXT;
      NEXT: state_n = (code_phase == LAST) ? DONE : SYNC;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign gen_sync  = (state == SYNC);
  assign cnt_rst   = (state == SYNC);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign found_now = (best_metric >= threshold) && !timeout_err;
  // Valid during the done pulse, then held until the next sweep
  assign found     = done ? found_now : found_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_phase  <= '0;
      best_phase  <= '0;
      best_metric <= '0;
      metric      <= '0;
      wd          <= '0;
      found_q     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            code_phase  <= '0;
            best_phase  <= '0;
            best_metric <= '0;
            found_q     <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        SYNC: wd <= '0;
        WAIT: begin
          if (sum_ready)   metric <= metric_n;
          else if (wd_end) timeout_err <= 1'b1;
          else             wd <= wd + 1'b1;
        end
        EVAL: begin
          // Strict compare keeps the earliest phase on ties
          if (code_phase == '0 || metric > best_metric) begin
            best_metric <= metric;
            best_phase  <= code_phase;
          end
        end
        NEXT: begin
          if (code_phase != LAST)
            code_phase <= code_phase + 10'd1;
        end
        DONE: found_q <= found_now;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_scheduler.sv
// Bench for acq_scheduler: directed and randomized sweeps
// against a reference model of the sweep outcome.
module tb_acq_scheduler;

  localparam int PC = 4;
  localparam int TO = 20;
  localparam int HF = 5000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] sum = '0;
  logic        sum_ready = 1'b0;
  logic [13:0] threshold = '0;
  logic        gen_sync, cnt_rst, busy, done, found;
  logic        timeout_err;
  logic [9:0]  code_phase, best_phase;
  logic [13:0] best_metric;

  int n_vec = 0;
  int n_err = 0;
  int sums[PC];
  int dly[PC];

  acq_scheduler #(
    .PHASE_COUNT(PC), .HALF(HF), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .sum(sum), .sum_ready(sum_ready),
    .threshold(threshold),
    .gen_sync(gen_sync), .cnt_rst(cnt_rst),
    .code_phase(code_phase), .busy(busy),
    .done(done), .found(found),
    .best_phase(best_phase),
    .best_metric(best_metric),
    .timeout_err(timeout_err)
  );

  always #50 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // Enters in SYNC of phase p; leaves in EVAL
  task automatic do_phase(input int p);
    chk("gen_sync", 32'(gen_sync), 1);
    chk("cnt_rst", 32'(cnt_rst), 1);
    chk("phase", 32'(code_phase), 32'(p));
    step;
    for (int d = 0; d < dly[p]; d++) begin
      start = (d == 0);
      step;
      start = 1'b0;
    end
    chk("wait_sync", 32'(gen_sync), 0);
    chk("wait_phase", 32'(code_phase), 32'(p));
    sum = 14'(sums[p]);
    sum_ready = 1'b1;
    step;
    sum_ready = 1'b0;
  endtask

  task automatic run_sweep(input int to_ph,
                           input int thr);
    int bm, bp, m, last;
    bit fnd;
    bm = 0;
    bp = 0;
    last = (to_ph < 0) ? PC - 1 : to_ph;
    for (int p = 0; p < PC; p++) begin
      if (to_ph >= 0 && p >= to_ph) break;
      m = (sums[p] >= HF) ? sums[p] - HF
                          : HF - sums[p];
      if (p == 0 || m > bm) begin
        bm = m;
        bp = p;
      end
    end
    fnd = (to_ph < 0) && (bm >= thr);

    threshold = 14'(thr);
    start = 1'b1;
    step;
    start = 1'b0;
    chk("busy_go", 32'(busy), 1);
    for (int p = 0; p <= last; p++) begin
      if (p == to_ph) begin
        chk("to_phase", 32'(code_phase), 32'(p));
        for (int k = 0; k < TO; k++) step;
        chk("to_early", 32'(done), 0);
        step;
      end else begin
        do_phase(p);
        chk("eval_done", 32'(done), 0);
        step;
        step;
      end
    end
    chk("done", 32'(done), 1);
    chk("found", 32'(found), 32'(fnd));
    chk("best_ph", 32'(best_phase), 32'(bp));
    chk("best_m", 32'(best_metric), 32'(bm));
    chk("to_err", 32'(timeout_err),
        32'(to_ph >= 0));
    chk("busy_dn", 32'(busy), 1);
    step;
    chk("done_1cy", 32'(done), 0);
    chk("busy_end", 32'(busy), 0);
    chk("found_hold", 32'(found), 32'(fnd));
    sum = 14'($urandom_range(0, 16383));
    sum_ready = 1'b1;
    step;
    sum_ready = 1'b0;
    step;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_sync", 32'(gen_sync), 0);
    chk("idle_bm", 32'(best_metric), 32'(bm));
    chk("idle_bp", 32'(best_phase), 32'(bp));
  endtask

  task automatic rand_fill;
    for (int p = 0; p < PC; p++) begin
      if (p > 0 && $urandom_range(0, 3) == 0)
        sums[p] = sums[p-1];
      else
        sums[p] = $urandom_range(0, 16383);
      dly[p] = $urandom_range(0, 6);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_sync"}, 32'(gen_sync), 0);
    chk({tag, "_crst"}, 32'(cnt_rst), 0);
    chk({tag, "_ph"}, 32'(code_phase), 0);
    chk({tag, "_bp"}, 32'(best_phase), 0);
    chk({tag, "_bm"}, 32'(best_metric), 0);
    chk({tag, "_fnd"}, 32'(found), 0);
    chk({tag, "_to"}, 32'(timeout_err), 0);
  endtask

  initial begin
    step;
    step;
    chk_zero("rst");
    rst = 1'b0;
    step;

    sums = '{5000, 5600, 4000, 5100};
    dly  = '{2, 0, 3, 1};
    run_sweep(-1, 500);
    chk("dir_bm", 32'(best_metric), 1000);
    run_sweep(-1, 1500);

    sums = '{5300, 4700, 5300, 5000};
    run_sweep(-1, 200);
    chk("tie_bp", 32'(best_phase), 0);

    sums = '{4000, 5100, 5100, 5100};
    run_sweep(1, 100);

    // Reset while phase 2 is in EVAL
    sums = '{5000, 7000, 9000, 100};
    dly  = '{1, 1, 1, 1};
    threshold = 14'd10;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      do_phase(p);
      if (p < 2) begin
        step;
        step;
      end
    end
    rst = 1'b1;
    #1;
    chk_zero("mid");
    for (int k = 0; k < 3; k++) begin
      step;
      chk("mid_nodone", 32'(done), 0);
    end
    rst = 1'b0;
    step;
    rand_fill();
    run_sweep(-1, $urandom_range(0, 12000));

    for (int i = 0; i < 10; i++) begin
      rand_fill();
      run_sweep(($urandom_range(0, 3) == 0)
                  ? int'($urandom_range(0, PC - 1))
                  : -1,
                $urandom_range(0, 12000));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
